ct_f_spsram_256x23_ctrl: RTL

Access controller that sits directly upstream of the 256x23 single-port tag SRAM and owns its CEN/GWEN/WEN/A/D pins. It initialises the array after reset and on an invalidate-all request. It serialises read and write requests from the pipeline through a valid/ready handshake. Because the SRAM honours only whole-word writes (it qualifies the write with WEN bit 0 only), the controller performs partial-mask writes as a read-modify-write.

---
 rtl/ct_f_spsram_256x23_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ct_f_spsram_256x23_ctrl.sv
// Access controller for the 256x23 single-port tag SRAM: init/invalidate sweep,
// valid/ready read/write serialisation, and read-modify-write for partial masks.
module ct_f_spsram_256x23_ctrl #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 23,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_all_req,
  output logic                  inv_busy,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {SWEEP, IDLE, RMW} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  inv_pend_q;
  logic [ADDR_WIDTH-1:0] stash_a_q;
  logic [DATA_WIDTH-1:0] stash_d_q, stash_m_q;
  logic                  rsp_vld_q;
  // Last driven SRAM pin values, replayed while the array is deselected
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  gwen_q, wen_q;

  logic acc, acc_rd, acc_full, acc_part;
  logic wen_b;

  assign inv_busy  = (state_q == SWEEP);
  assign req_rdy   = (state_q == IDLE) && !inv_all_req && !inv_pend_q;
  assign acc       = req_vld && req_rdy;
  assign acc_rd    = acc && !req_wr;
  assign acc_full  = acc && req_wr && (&req_wmask);
  assign acc_part  = acc && req_wr && !(&req_wmask);
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = ram_q;
  assign ram_wen   = {DATA_WIDTH{wen_b}};

  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = gwen_q;
    wen_b    = wen_q;
    ram_a    = a_q;
    ram_d    = d_q;
    case (state_q)
      SWEEP: begin
        ram_cen  = 1'b0;
        ram_gwen = 1'b0;
        wen_b    = 1'b0;
        ram_a    = cnt_q;
        ram_d    = INIT_VAL;
      end
      IDLE: begin
        if (acc_rd || acc_part) begin
          ram_cen  = 1'b0;
          ram_gwen = 1'b1;
          ram_a    = req_addr;
        end else if (acc_full) begin
          ram_cen  = 1'b0;
          ram_gwen = 1'b0;
          wen_b    = 1'b0;
          ram_a    = req_addr;
          ram_d    = req_wdata;
        end
      end
      RMW: begin
        ram_cen  = 1'b0;
        ram_gwen = 1'b0;
        wen_b    = 1'b0;
        ram_a    = stash_a_q;
        ram_d    = (ram_q & ~stash_m_q) | (stash_d_q & stash_m_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= SWEEP;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      stash_a_q  <= '0;
      stash_d_q  <= '0;
      stash_m_q  <= '0;
      rsp_vld_q  <= 1'b0;
      a_q        <= '0;
      d_q        <= INIT_VAL;
      gwen_q     <= 1'b0;
      wen_q      <= 1'b0;
    end else begin
      rsp_vld_q <= acc_rd;
      if (!ram_cen) begin
        a_q    <= ram_a;
        d_q    <= ram_d;
        gwen_q <= ram_gwen;
        wen_q  <= wen_b;
      end
      case (state_q)
        SWEEP: begin
          // inv_all_req is ignored here: the running sweep already covers it
          if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (inv_all_req || inv_pend_q) begin
            inv_pend_q <= 1'b0;
            state_q    <= SWEEP;
          end else if (acc_part) begin
            stash_a_q <= req_addr;
            stash_d_q <= req_wdata;
            stash_m_q <= req_wmask;
            state_q   <= RMW;
          end
        end
        RMW: begin
          if (inv_all_req) inv_pend_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= SWEEP;
      endcase
    end
  end

endmodule
